// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fc_layer_sequencer
//  Purpose  : Time-multiplexed controller for one fully connected layer.
//             A latched input vector is multiplied against LAYER_WIDTH^2
//             weights streamed from a synchronous weight memory, one word per
//             cycle, through a single MAC. The finished output vector is
//             offered downstream through a valid/ready handshake.
//  Ports    : clk, rst            clock / asynchronous active-high reset
//             in_valid, in_ready  input-vector handshake
//             input_vector        element i at [i*DATA_WIDTH +: DATA_WIDTH]
//             w_rd_en, w_addr     weight memory read strobe / address
//             w_data              weight read data, valid one cycle after strobe
//             out_valid, out_ready output-vector handshake
//             output_vector       element j at [j*DATA_WIDTH +: DATA_WIDTH]
//             busy                sequencer is not idle
//  Revision : 1.0  initial release
// ============================================================================
module fc_layer_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int LAYER_WIDTH = 2,
  parameter int ADDR_WIDTH  = $clog2(LAYER_WIDTH*LAYER_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*LAYER_WIDTH-1:0] input_vector,
  output logic                              w_rd_en,
  output logic [ADDR_WIDTH-1:0]             w_addr,
  input  logic [DATA_WIDTH-1:0]             w_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*LAYER_WIDTH-1:0] output_vector,
  output logic                              busy
);

  localparam int                    N         = LAYER_WIDTH * LAYER_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]             cnt_q, cnt_d;
  logic                              pend_q;
  logic [ADDR_WIDTH-1:0]             paddr_q;
  logic [DATA_WIDTH-1:0]             in_q   [LAYER_WIDTH];
  logic [DATA_WIDTH-1:0]             acc_q  [LAYER_WIDTH];
  logic [DATA_WIDTH-1:0]             acc_d  [LAYER_WIDTH];
  logic [DATA_WIDTH*LAYER_WIDTH-1:0] acc_flat;
  logic [DATA_WIDTH*LAYER_WIDTH-1:0] out_q;
  logic                              accept;

  assign accept = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. in_ready is forced low while reset is asserted so that an
  // upstream stage never sees a handshake during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    w_rd_en   = (state_q == S_RUN);
    w_addr    = (state_q == S_RUN) ? cnt_q : '0;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign output_vector = out_q;

  // --------------------------------------------------------------------------
  // MAC update for the word returning this cycle. The pending address k maps
  // to input element i = k / LAYER_WIDTH and output column j = k % LAYER_WIDTH;
  // the decode is done by matching against every constant (i, j) pair so no
  // divider is needed. Products and sums wrap at DATA_WIDTH bits.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < LAYER_WIDTH; j++) begin
      acc_d[j] = acc_q[j];
    end
    if (pend_q) begin
      for (int i = 0; i < LAYER_WIDTH; i++) begin
        for (int j = 0; j < LAYER_WIDTH; j++) begin
          if (paddr_q == ADDR_WIDTH'(i*LAYER_WIDTH + j)) begin
            acc_d[j] = acc_q[j] + in_q[i] * w_data;
          end
        end
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int j = 0; j < LAYER_WIDTH; j++) begin
      acc_flat[j*DATA_WIDTH +: DATA_WIDTH] = acc_d[j];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. The pending flag/address track the read issued in the
  // previous cycle; clearing them on reset drops any read still in flight.
  // The output register is loaded from the updated accumulators in DRAIN so
  // the final returning word is included.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      paddr_q <= '0;
      out_q   <= '0;
      for (int i = 0; i < LAYER_WIDTH; i++) begin
        in_q[i]  <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      pend_q  <= w_rd_en;
      paddr_q <= w_addr;
      if (accept) begin
        for (int i = 0; i < LAYER_WIDTH; i++) begin
          in_q[i]  <= input_vector[i*DATA_WIDTH +: DATA_WIDTH];
          acc_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < LAYER_WIDTH; i++) begin
          acc_q[i] <= acc_d[i];
        end
      end
      if (state_q == S_DRAIN) begin
        out_q <= acc_flat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fc_layer_sequencer
//  Purpose  : Self-checking bench for fc_layer_sequencer with a synchronous
//             weight memory model and a matrix-vector reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fc_layer_sequencer;

  localparam int DW = 4;
  localparam int LW = 2;
  localparam int N  = LW * LW;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [DW*LW-1:0] input_vector = '0;
  logic           in_ready;
  logic           w_rd_en;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_data = '0;
  logic           out_valid;
  logic [DW*LW-1:0] output_vector;
  logic           busy;

  logic [DW-1:0]  mem [N];

  int checks = 0;
  int errors = 0;

  fc_layer_sequencer #(
    .DATA_WIDTH (DW),
    .LAYER_WIDTH(LW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_vector (input_vector),
    .w_rd_en      (w_rd_en),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_vector(output_vector),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= mem[w_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // out[j] = sum_i in[i] * W[i][j], modulo 2^DW
  function automatic logic [DW*LW-1:0] model(input logic [DW*LW-1:0] v);
    logic [DW*LW-1:0] r;
    int s;
    int a;
    int b;
    r = '0;
    for (int j = 0; j < LW; j++) begin
      s = 0;
      for (int i = 0; i < LW; i++) begin
        a = int'(v[i*DW +: DW]);
        b = int'(mem[i*LW + j]);
        s = s + a * b;
      end
      r[j*DW +: DW] = DW'(s % (1 << DW));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) check("busy_vs_in_ready", {31'b0, busy}, {31'b0, !in_ready});
  endtask

  task automatic junk_inputs(input bit junk);
    if (junk) begin
      in_valid     = 1'($urandom);
      input_vector = (DW*LW)'($urandom);
    end
  endtask

  // Accept vec, check the read sequence, latency, a DONE stall of `stall`
  // cycles, then the handshake back to IDLE.
  task automatic run_vec(input logic [DW*LW-1:0] vec, input int stall,
                         input bit junk, input logic [DW*LW-1:0] exp);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    input_vector = vec;
    tick();                                   // accept edge E
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      junk_inputs(junk);
      out_ready = 1'($urandom);               // no effect outside DONE
      check("rd_en_run", {31'b0, w_rd_en}, 32'd1);
      check("w_addr_seq", {30'b0, w_addr}, k);
      check("in_ready_run", {31'b0, in_ready}, 32'd0);
      check("out_valid_run", {31'b0, out_valid}, 32'd0);
      tick();
    end
    junk_inputs(junk);
    check("rd_en_drain", {31'b0, w_rd_en}, 32'd0);
    check("out_valid_drain", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick();                                   // E+N+1
    check("out_valid_latency", {31'b0, out_valid}, 32'd1);
    check("result", {24'b0, output_vector}, {24'b0, exp});
    for (int s = 0; s < stall; s++) begin
      junk_inputs(junk);
      tick();
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_output_stable", {24'b0, output_vector}, {24'b0, exp});
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_rd_en", {31'b0, w_rd_en}, 32'd0);
    end
    out_ready = 1'b1;
    tick();                                   // handshake edge
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    check("output_hold_after_hs", {24'b0, output_vector}, {24'b0, exp});
  endtask

  initial begin
    logic [DW*LW-1:0] vec;

    // Reset values while rst is high
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_rd_en", {31'b0, w_rd_en}, 32'd0);
    check("rst_w_addr", {30'b0, w_addr}, 32'd0);
    check("rst_output", {24'b0, output_vector}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    mem[0] = 4'd3; mem[1] = 4'd4; mem[2] = 4'd5; mem[3] = 4'd6;

    // [1,2] -> [13,0]
    run_vec(8'h21, 0, 1'b0, 8'h0D);
    // Long DONE stall
    run_vec(8'h21, 10, 1'b0, 8'h0D);
    // Back-to-back [1,2] then [3,1] -> [14,2], second accept right after handshake
    run_vec(8'h21, 0, 1'b0, 8'h0D);
    run_vec(8'h13, 0, 1'b0, 8'h2E);

    // Reset while cnt==2 in RUN
    in_valid     = 1'b1;
    input_vector = 8'h21;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_addr", {30'b0, w_addr}, 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_rd_en", {31'b0, w_rd_en}, 32'd0);
    check("midrst_w_addr", {30'b0, w_addr}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_output", {24'b0, output_vector}, 32'd0);
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_vec(8'h11, 2, 1'b0, 8'hA8);

    // Junk on in_valid/input_vector during RUN/DRAIN/DONE
    run_vec(8'h13, 3, 1'b1, 8'h2E);

    // Randomised vectors, weights and stalls against the reference model
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < N; k++) mem[k] = DW'($urandom);
      vec = (DW*LW)'($urandom);
      run_vec(vec, int'($urandom_range(0, 3)), 1'b1, model(vec));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
